// File: rtl/usb_rx_ctrl_param.sv
// USB full-speed receive control unit: sequences SYNC/PID/payload/EOP, checks the PID
// complement, decodes token address/endpoint and strips the CRC16 from DATA packets.
module usb_rx_ctrl_param #(
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned ENDP_COUNT  = 1,
    parameter bit          ADDR_CHECK  = 1'b1
) (
    input  logic                               i_clk,
    input  logic                               i_n_rst,
    input  logic                               i_d_edge,
    input  logic                               i_shift_enable,
    input  logic                               i_byte_received,
    input  logic [7:0]                         i_rcv_data,
    input  logic                               i_eop,
    input  logic                               i_buffer_full,
    input  logic [6:0]                         i_dev_addr,
    output logic                               o_disable_timer,
    output logic                               o_rcving,
    output logic                               o_flush,
    output logic                               o_r_error,
    output logic                               o_w_enable,
    output logic [7:0]                         o_w_data,
    output logic [3:0]                         o_rx_packet,
    output logic                               o_rx_valid,
    output logic [6:0]                         o_token_addr,
    output logic [3:0]                         o_token_endp,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   o_data_count
);

    localparam int unsigned CntW = $clog2(MAX_PAYLOAD + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_PAYLOAD);

    typedef enum logic [3:0] {
        StIdle, StStart, StSyncWait, StSyncChk, StPidWait, StPidChk, StToken,
        StData, StHsEop, StDoneEop, StError, StErrEop, StEidle
    } state_t;

    state_t            r_state, w_state_d;
    logic              r_byte_dly;
    logic [3:0]        r_pid, w_pid_d;
    logic [7:0]        r_tok_b0, w_tok_b0_d;
    logic              r_tok_cnt, w_tok_cnt_d;
    logic [7:0]        r_h0, w_h0_d, r_h1, w_h1_d;
    logic [1:0]        r_dat_cnt, w_dat_cnt_d;
    logic [CntW-1:0]   r_data_count, w_data_count_d;
    logic [6:0]        r_token_addr, w_token_addr_d;
    logic [3:0]        r_token_endp, w_token_endp_d;
    logic              w_eop_bit;
    logic [6:0]        w_tok_addr;
    logic [3:0]        w_tok_endp;
    logic              w_tok_bad;

    // An EOP bit is deferred while a byte is pending so the byte is always handled first.
    assign w_eop_bit  = i_eop && i_shift_enable && !i_byte_received && !r_byte_dly;
    assign w_tok_addr = r_tok_b0[6:0];
    assign w_tok_endp = {i_rcv_data[2:0], r_tok_b0[7]};
    assign w_tok_bad  = (ADDR_CHECK && (w_tok_addr != i_dev_addr)) ||
                        ({28'd0, w_tok_endp} >= ENDP_COUNT);

    assign o_w_data     = r_h0;
    assign o_token_addr = r_token_addr;
    assign o_token_endp = r_token_endp;
    assign o_data_count = r_data_count;

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state      <= StIdle;
            r_byte_dly   <= 1'b0;
            r_pid        <= 4'd0;
            r_tok_b0     <= 8'd0;
            r_tok_cnt    <= 1'b0;
            r_h0         <= 8'd0;
            r_h1         <= 8'd0;
            r_dat_cnt    <= 2'd0;
            r_data_count <= '0;
            r_token_addr <= 7'd0;
            r_token_endp <= 4'd0;
        end else begin
            r_state      <= w_state_d;
            r_byte_dly   <= i_byte_received;
            r_pid        <= w_pid_d;
            r_tok_b0     <= w_tok_b0_d;
            r_tok_cnt    <= w_tok_cnt_d;
            r_h0         <= w_h0_d;
            r_h1         <= w_h1_d;
            r_dat_cnt    <= w_dat_cnt_d;
            r_data_count <= w_data_count_d;
            r_token_addr <= w_token_addr_d;
            r_token_endp <= w_token_endp_d;
        end
    end

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        w_state_d       = r_state;
        w_pid_d         = r_pid;
        w_tok_b0_d      = r_tok_b0;
        w_tok_cnt_d     = r_tok_cnt;
        w_h0_d          = r_h0;
        w_h1_d          = r_h1;
        w_dat_cnt_d     = r_dat_cnt;
        w_data_count_d  = r_data_count;
        w_token_addr_d  = r_token_addr;
        w_token_endp_d  = r_token_endp;
        o_disable_timer = 1'b0;
        o_rcving        = 1'b1;
        o_flush         = 1'b0;
        o_r_error       = 1'b0;
        o_w_enable      = 1'b0;
        o_rx_valid      = 1'b0;
        o_rx_packet     = 4'd0;

        case (r_state)
            StIdle: begin
                o_disable_timer = 1'b1;
                o_rcving        = 1'b0;
                if (i_d_edge) w_state_d = StStart;
            end
            StStart: begin
                o_flush        = 1'b1;
                w_data_count_d = '0;
                w_tok_cnt_d    = 1'b0;
                w_dat_cnt_d    = 2'd0;
                w_h0_d         = 8'd0;
                w_h1_d         = 8'd0;
                w_state_d      = StSyncWait;
            end
            StSyncWait: begin
                if (i_byte_received) w_state_d = StSyncChk;
                else if (w_eop_bit)  w_state_d = StErrEop;
            end
            StSyncChk: begin
                w_state_d = (i_rcv_data == 8'h80) ? StPidWait : StError;
            end
            StPidWait: begin
                if (i_byte_received) w_state_d = StPidChk;
                else if (w_eop_bit)  w_state_d = StErrEop;
            end
            StPidChk: begin
                if (i_rcv_data[7:4] != ~i_rcv_data[3:0]) begin
                    w_state_d = StError;
                end else begin
                    w_pid_d = i_rcv_data[3:0];
                    case (i_rcv_data[3:0])
                        4'h1, 4'h9, 4'hD: w_state_d = StToken;
                        4'h3, 4'hB:       w_state_d = StData;
                        4'h2, 4'hA, 4'hE: w_state_d = StHsEop;
                        default:          w_state_d = StError;
                    endcase
                end
            end
            StToken: begin
                if (r_byte_dly) begin
                    if (!r_tok_cnt) begin
                        w_tok_b0_d  = i_rcv_data;
                        w_tok_cnt_d = 1'b1;
                    end else if (w_tok_bad) begin
                        w_state_d = StError;
                    end else begin
                        w_token_addr_d = w_tok_addr;
                        w_token_endp_d = w_tok_endp;
                        w_state_d      = StHsEop;
                    end
                end else if (w_eop_bit) begin
                    w_state_d = StErrEop;
                end
            end
            StData: begin
                if (r_byte_dly) begin
                    // Two-byte holdback: the oldest byte is released only once two newer
                    // bytes exist, so the trailing CRC16 is never written.
                    if (r_dat_cnt == 2'd2) begin
                        if (i_buffer_full || (r_data_count == MaxCnt)) begin
                            w_state_d = StError;
                        end else begin
                            o_w_enable     = 1'b1;
                            w_data_count_d = r_data_count + 1'b1;
                            w_h0_d         = r_h1;
                            w_h1_d         = i_rcv_data;
                        end
                    end else begin
                        w_h0_d      = r_h1;
                        w_h1_d      = i_rcv_data;
                        w_dat_cnt_d = r_dat_cnt + 2'd1;
                    end
                end else if (w_eop_bit) begin
                    w_state_d = (r_dat_cnt == 2'd2) ? StDoneEop : StErrEop;
                end
            end
            StHsEop: begin
                if (r_byte_dly)     w_state_d = StError;
                else if (w_eop_bit) w_state_d = StDoneEop;
            end
            StDoneEop: begin
                if (w_eop_bit) begin
                    o_rx_valid  = 1'b1;
                    o_rx_packet = r_pid;
                    w_state_d   = StIdle;
                end
            end
            StError: begin
                o_r_error = 1'b1;
                if (w_eop_bit) w_state_d = StErrEop;
            end
            StErrEop: begin
                o_r_error = 1'b1;
                o_rcving  = 1'b0;
                if (w_eop_bit) w_state_d = StEidle;
            end
            StEidle: begin
                o_r_error       = 1'b1;
                o_disable_timer = 1'b1;
                o_rcving        = 1'b0;
                if (i_d_edge) w_state_d = StStart;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_rx_ctrl_param.sv
// Randomized bench for usb_rx_ctrl_param with a packet-level reference model.
module tb_usb_rx_ctrl_param;

    localparam int unsigned MP = 8;
    localparam int unsigned EC = 4;
    localparam int unsigned CW = $clog2(MP + 1);

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          d_edge = 1'b0, shift_enable = 1'b0, byte_received = 1'b0;
    logic [7:0]    rcv_data = 8'd0;
    logic          eop = 1'b0, buffer_full = 1'b0;
    logic [6:0]    dev_addr = 7'd1;
    logic          disable_timer, rcving, flush, r_error, w_enable, rx_valid;
    logic [7:0]    w_data;
    logic [3:0]    rx_packet, token_endp;
    logic [6:0]    token_addr;
    logic [CW-1:0] data_count;

    usb_rx_ctrl_param #(.MAX_PAYLOAD(MP), .ENDP_COUNT(EC), .ADDR_CHECK(1'b1)) dut (
        .i_clk(clk), .i_n_rst(n_rst), .i_d_edge(d_edge), .i_shift_enable(shift_enable),
        .i_byte_received(byte_received), .i_rcv_data(rcv_data), .i_eop(eop),
        .i_buffer_full(buffer_full), .i_dev_addr(dev_addr),
        .o_disable_timer(disable_timer), .o_rcving(rcving), .o_flush(flush),
        .o_r_error(r_error), .o_w_enable(w_enable), .o_w_data(w_data),
        .o_rx_packet(rx_packet), .o_rx_valid(rx_valid), .o_token_addr(token_addr),
        .o_token_endp(token_endp), .o_data_count(data_count)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    logic [7:0]  pkt_q[$];
    logic [7:0]  got_w[$];
    logic [7:0]  exp_w[$];
    int unsigned rxv_cnt;
    logic [3:0]  rx_pid;

    // Reference state
    logic        m_err, m_valid;
    logic [3:0]  m_pid;
    logic [6:0]  m_taddr = 7'd0;
    logic [3:0]  m_tendp = 4'd0;
    int unsigned m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Observe FIFO writes and completion pulses mid-cycle.
    always @(negedge clk) begin
        if (n_rst) begin
            if (w_enable) got_w.push_back(w_data);
            if (rx_valid) begin
                rxv_cnt++;
                rx_pid = rx_packet;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_period();
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat (8) bit_period();
        rcv_data      = b;
        byte_received = 1'b1;
        tick();
        byte_received = 1'b0;
    endtask

    task automatic start_pkt();
        got_w.delete();
        rxv_cnt = 0;
        d_edge  = 1'b1;
        tick();
        d_edge  = 1'b0;
        check("start_flush", 32'(flush), 32'd1);
        check("start_err_clr", 32'(r_error), 32'd0);
    endtask

    // Packet-level expectation from the protocol rules.
    task automatic model(input logic bf);
        int unsigned n, nd, np, nw;
        logic [7:0]  p;
        logic [6:0]  a;
        logic [3:0]  e;
        m_err = 1'b0;
        m_count = 0;
        nw = 0;
        exp_w.delete();
        n = pkt_q.size();
        p = (n >= 2) ? pkt_q[1] : 8'h00;
        if (n < 2 || pkt_q[0] != 8'h80) m_err = 1'b1;
        else if (p[7:4] != ~p[3:0]) m_err = 1'b1;
        else begin
            m_pid = p[3:0];
            if (p[3:0] == 4'h1 || p[3:0] == 4'h9 || p[3:0] == 4'hD) begin
                if (n != 4) m_err = 1'b1;
                else begin
                    a = pkt_q[2][6:0];
                    e = {pkt_q[3][2:0], pkt_q[2][7]};
                    if (a != dev_addr || e >= EC) m_err = 1'b1;
                    else begin
                        m_taddr = a;
                        m_tendp = e;
                    end
                end
            end else if (p[3:0] == 4'h3 || p[3:0] == 4'hB) begin
                nd = n - 2;
                if (nd < 2) m_err = 1'b1;
                else begin
                    np = nd - 2;
                    if (bf && np > 0) m_err = 1'b1;
                    else if (np > MP) begin
                        m_err = 1'b1;
                        nw = MP;
                    end else nw = np;
                    for (int i = 0; i < int'(nw); i++) exp_w.push_back(pkt_q[2 + i]);
                    m_count = nw;
                end
            end else if (p[3:0] == 4'h2 || p[3:0] == 4'hA || p[3:0] == 4'hE) begin
                if (n != 2) m_err = 1'b1;
            end else m_err = 1'b1;
        end
        m_valid = !m_err;
    endtask

    task automatic run_pkt(input string tag, input logic bf);
        model(bf);
        buffer_full = bf;
        start_pkt();
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        repeat (2) bit_period();
        eop = 1'b1;
        repeat (2) bit_period();
        eop = 1'b0;
        repeat (3) bit_period();
        buffer_full = 1'b0;
        check({tag, "_err"}, 32'(r_error), 32'(m_err));
        check({tag, "_nvalid"}, rxv_cnt, m_valid ? 32'd1 : 32'd0);
        if (m_valid && rxv_cnt == 1) check({tag, "_pid"}, 32'(rx_pid), 32'(m_pid));
        check({tag, "_nwr"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check({tag, "_wdata"}, 32'(got_w[i]), 32'(exp_w[i]));
        check({tag, "_taddr"}, 32'(token_addr), 32'(m_taddr));
        check({tag, "_tendp"}, 32'(token_endp), 32'(m_tendp));
        check({tag, "_dcnt"}, 32'(data_count), m_count);
        check({tag, "_rcving"}, 32'(rcving), 32'd0);
        check({tag, "_distmr"}, 32'(disable_timer), 32'd1);
    endtask

    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

    initial begin
        logic [3:0]  hs[3];
        logic [3:0]  pids[3];
        int unsigned kind, np;
        logic [6:0]  a;
        logic [3:0]  e;

        hs[0] = 4'h2; hs[1] = 4'hA; hs[2] = 4'hE;
        pids[0] = 4'h1; pids[1] = 4'h9; pids[2] = 4'hD;

        #2;
        check("rst_distmr", 32'(disable_timer), 32'd1);
        check("rst_rcving", 32'(rcving), 32'd0);
        check("rst_err", 32'(r_error), 32'd0);
        check("rst_wen", 32'(w_enable), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_dcnt", 32'(data_count), 32'd0);
        #11 n_rst = 1'b1;
        tick();

        // Directed packets
        pkt_q = '{8'h80, 8'hD2};                         run_pkt("ack", 1'b0);
        dev_addr = 7'd1;
        pkt_q = '{8'h80, 8'hE1, 8'h81, 8'h01};           run_pkt("out_tok", 1'b0);
        pkt_q = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB}; run_pkt("data0", 1'b0);
        pkt_q = '{8'h80, 8'hD3};                         run_pkt("bad_pid", 1'b0);
        pkt_q = '{8'h80, 8'h5A};                         run_pkt("nak", 1'b0);
        pkt_q = '{8'h80, 8'h4B};
        for (int i = 0; i < int'(MP) + 3; i++) pkt_q.push_back(8'(i + 8'h40));
        run_pkt("overlen", 1'b0);
        pkt_q = '{8'h80, 8'h4B, 8'h01, 8'h02, 8'h03};   run_pkt("buf_full", 1'b1);
        pkt_q = '{8'h80, 8'h69, 8'h05, 8'h00};           run_pkt("bad_addr", 1'b0);
        pkt_q = '{8'h80, 8'hC3, 8'h99};                  run_pkt("short_dat", 1'b0);

        // Randomized packets
        for (int t = 0; t < 40; t++) begin
            dev_addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd1;
            kind = $urandom_range(0, 5);
            pkt_q = '{8'h80};
            case (kind)
                0: begin
                    pkt_q.push_back(pid_byte(hs[$urandom_range(0, 2)]));
                    if ($urandom_range(0, 4) == 0) pkt_q.push_back(8'($urandom));
                end
                1: begin
                    a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : dev_addr;
                    e = 4'($urandom_range(0, 7));
                    pkt_q.push_back(pid_byte(pids[$urandom_range(0, 2)]));
                    pkt_q.push_back({e[0], a});
                    if ($urandom_range(0, 5) != 0) pkt_q.push_back({5'($urandom), e[3:1]});
                end
                2, 3: begin
                    pkt_q.push_back(pid_byte($urandom_range(0, 1) ? 4'h3 : 4'hB));
                    np = $urandom_range(0, MP + 4);
                    for (int i = 0; i < int'(np); i++) pkt_q.push_back(8'($urandom));
                end
                4: pkt_q.push_back(8'($urandom));
                default: begin
                    pkt_q[0] = 8'($urandom_range(0, 1) ? 8'h00 : 8'($urandom));
                    pkt_q.push_back(pid_byte(4'h3));
                end
            endcase
            run_pkt("rand", ((kind == 2) && ($urandom_range(0, 5) == 0)) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset in the middle of a DATA packet
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        #3 n_rst = 1'b0;
        #1;
        m_taddr = 7'd0;
        m_tendp = 4'd0;
        check("mrst_distmr", 32'(disable_timer), 32'd1);
        check("mrst_rcving", 32'(rcving), 32'd0);
        check("mrst_wen", 32'(w_enable), 32'd0);
        check("mrst_dcnt", 32'(data_count), 32'd0);
        check("mrst_taddr", 32'(token_addr), 32'(m_taddr));
        #2 n_rst = 1'b1;
        eop = 1'b1;
        repeat (2) bit_period();
        eop = 1'b0;
        repeat (2) bit_period();
        check("mrst_nvalid", rxv_cnt, 32'd0);
        check("mrst_idle_distmr", 32'(disable_timer), 32'd1);
        check("mrst_idle_err", 32'(r_error), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1);
    end

endmodule
